// File: rtl/act_unpack.sv
// Unpacks 32-bit words of four 8-bit activation codes into one scaled, zero-extended
// element per clock, with row-end marking and a sticky out-of-range code flag.
module act_unpack #(
    parameter int FRAC_SHIFT = 0,
    parameter int MAX_ACT    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_last,
    input  logic [2:0]  s_count,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        err_range
);

    typedef enum logic {EMPTY, BUSY} state_t;

    localparam logic [7:0] MAX_CODE = MAX_ACT[7:0];

    state_t      state_reg;
    logic [31:0] word_reg;
    logic [1:0]  lane_reg;
    logic [1:0]  last_lane_reg;
    logic        last_reg;
    logic        err_reg;

    logic [7:0]  lane_bytes [4];
    logic [7:0]  cur_byte;
    logic        at_last_lane;
    logic        in_xfer;
    logic        out_xfer;
    logic [1:0]  last_lane_next;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_bytes[gi] = word_reg[gi*8 +: 8];
    end

    assign cur_byte     = lane_bytes[lane_reg];
    assign at_last_lane = (lane_reg == last_lane_reg);

    assign m_valid   = (state_reg == BUSY);
    assign m_data    = 32'(cur_byte) << FRAC_SHIFT;
    assign m_last    = m_valid && last_reg && at_last_lane;
    assign err_range = err_reg;

    // Ready while idle, or when the final lane leaves this cycle so words chain without bubbles.
    assign s_ready  = (state_reg == EMPTY) || (m_ready && at_last_lane);
    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    // Only a row-ending word may be short; a count of 0 (or out of range) means a full word.
    assign last_lane_next = (s_last && s_count != 3'd0 && s_count < 3'd4)
                          ? (s_count[1:0] - 2'd1) : 2'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            word_reg      <= '0;
            lane_reg      <= '0;
            last_lane_reg <= 2'd3;
            last_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            if (out_xfer && cur_byte > MAX_CODE) begin
                err_reg <= 1'b1;
            end
            if (in_xfer) begin
                state_reg     <= BUSY;
                word_reg      <= s_data;
                lane_reg      <= 2'd0;
                last_lane_reg <= last_lane_next;
                last_reg      <= s_last;
            end else if (out_xfer) begin
                if (at_last_lane) begin
                    state_reg <= EMPTY;
                end else begin
                    lane_reg <= lane_reg + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_act_unpack.sv
// Directed bench for act_unpack: table of words with hand-computed lane outputs,
// plus stall, mid-word reset and scaled/out-of-range sequences.
module tb_act_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic [2:0]  s_count;
    logic        m_ready;

    logic        s_ready0, m_valid0, m_last0, err0;
    logic [31:0] m_data0;
    logic        s_ready1, m_valid1, m_last1, err1;
    logic [31:0] m_data1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_out    = 0;
    int first_cyc = -1;
    int last_cyc  = -1;

    logic [31:0] exp_data_q[$];
    logic        exp_last_q[$];

    typedef struct {
        logic [31:0]      word;
        logic             last;
        logic [2:0]       count;
        int               n;
        logic [3:0][7:0]  exp;
        logic             exp_last;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    act_unpack dut0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
        .s_last(s_last), .s_count(s_count), .m_data(m_data0), .m_valid(m_valid0),
        .m_ready(m_ready), .m_last(m_last0), .err_range(err0)
    );

    act_unpack #(.FRAC_SHIFT(16), .MAX_ACT(6)) dut1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
        .s_last(s_last), .s_count(s_count), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(m_ready), .m_last(m_last1), .err_range(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard on the default instance: every output transfer must match the queue head.
    always @(negedge clk) begin
        if (m_valid0 && m_ready) begin
            $display("out t=%0d data=%h last=%0b", cyc, m_data0, m_last0);
            if (exp_data_q.size() == 0) begin
                check("unexpected_output", m_data0, 32'hxxxx_xxxx);
            end else begin
                check("out_data", m_data0, exp_data_q.pop_front());
                check("out_last", {31'd0, m_last0}, {31'd0, exp_last_q.pop_front()});
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            n_out++;
        end
    end

    task automatic expect_word(input logic [3:0][7:0] bytes, input int n, input logic lst);
        for (int i = 0; i < n; i++) begin
            exp_data_q.push_back({24'd0, bytes[i]});
            exp_last_q.push_back(lst && (i == n - 1));
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [31:0] w, input logic l, input logic [2:0] c);
        bit done = 0;
        s_data = w; s_last = l; s_count = c; s_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = s_ready0;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && exp_data_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_remaining", exp_data_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h04030201, 1'b0, 3'd0, 4, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0};
        vecs[1] = '{32'h06050403, 1'b0, 3'd0, 4, {8'd6, 8'd5, 8'd4, 8'd3}, 1'b0};
        vecs[2] = '{32'h02010000, 1'b1, 3'd4, 4, {8'd2, 8'd1, 8'd0, 8'd0}, 1'b1};
        vecs[3] = '{32'h00000605, 1'b1, 3'd2, 2, {8'd0, 8'd0, 8'd6, 8'd5}, 1'b1};
        vecs[4] = '{32'h01020304, 1'b1, 3'd0, 4, {8'd1, 8'd2, 8'd3, 8'd4}, 1'b1};
        vecs[5] = '{32'h06050506, 1'b1, 3'd1, 1, {8'd0, 8'd0, 8'd0, 8'd6}, 1'b1};
        vecs[6] = '{32'h00010203, 1'b0, 3'd1, 4, {8'd0, 8'd1, 8'd2, 8'd3}, 1'b0};

        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_count = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_m_valid", {31'd0, m_valid0}, 32'd0);
        check("rst_m_last", {31'd0, m_last0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        check("rst_m_data", m_data0, 32'd0);
        check("rst_s_ready", {31'd0, s_ready0}, 32'd1);
        @(posedge clk);
        #1;

        // Table: all words back-to-back with the sink always ready.
        m_ready = 1'b1;
        n_out = 0; first_cyc = -1; last_cyc = -1;
        foreach (vecs[k]) expect_word(vecs[k].exp, vecs[k].n, vecs[k].last && vecs[k].exp_last);
        foreach (vecs[k]) send(vecs[k].word, vecs[k].last, vecs[k].count);
        wait_drain();
        check("table_out_count", n_out, 32'd23);
        check("table_no_gaps", last_cyc - first_cyc, 32'd22);
        check("table_err_clear", {31'd0, err0}, 32'd0);

        // Stall on lane 1 for three cycles.
        m_ready = 1'b0;
        expect_word({8'd4, 8'd3, 8'd2, 8'd1}, 4, 1'b0);
        send(32'h04030201, 1'b0, 3'd0);
        @(negedge clk);
        check("lat_m_valid", {31'd0, m_valid0}, 32'd1);
        check("lat_m_data", m_data0, 32'd1);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        s_data = 32'h05050505; s_valid = 1'b1; s_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_m_data", m_data0, 32'd2);
            check("stall_m_valid", {31'd0, m_valid0}, 32'd1);
            check("stall_s_ready", {31'd0, s_ready0}, 32'd0);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_drain();

        // Reset while lane 2 is pending.
        expect_word({8'd4, 8'd3, 8'd2, 8'd1}, 2, 1'b0);
        send(32'h04030201, 1'b0, 3'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_valid", {31'd0, m_valid0}, 32'd0);
        check("midrst_m_data", m_data0, 32'd0);
        check("midrst_s_ready", {31'd0, s_ready0}, 32'd1);
        check("midrst_queue", exp_data_q.size(), 32'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        expect_word({8'd0, 8'd0, 8'd9, 8'd1}, 2, 1'b1);
        send(32'h00000901, 1'b1, 3'd2);
        wait_drain();
        check("post_rst_err", {31'd0, err0}, 32'd1);

        // Scaled instance with an out-of-range code.
        do_reset();
        m_ready = 1'b0;
        expect_word({8'd0, 8'd0, 8'd0, 8'd7}, 1, 1'b1);
        send(32'h00000007, 1'b1, 3'd1);
        @(negedge clk);
        check("shift_m_data", m_data1, 32'h00070000);
        check("shift_m_last", {31'd0, m_last1}, 32'd1);
        check("shift_err_before", {31'd0, err1}, 32'd0);
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("shift_err_set", {31'd0, err1}, 32'd1);
        check("shift_m_valid_done", {31'd0, m_valid1}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("err_held", {31'd0, err1}, 32'd1);
        check("err_held_dflt", {31'd0, err0}, 32'd1);
        do_reset();
        @(negedge clk);
        check("err_cleared", {31'd0, err1}, 32'd0);
        check("exp_queue_empty", exp_data_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
